adder_tree_acc: RTL and testbench

//   Parametrised, pipelined N-input signed adder tree with a frame accumulator.

---
 rtl/acc_pkg.sv | 60 ++++++
 rtl/adder_tree_level.sv | 68 ++++++
 rtl/adder_tree_acc.sv | 158 +++++++++++++++
 tb/tb_adder_tree_acc.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared helpers for the adder tree accumulator
// Purpose: tree sizing helpers (clog2, per-level operand count) and the
//          signed saturate/truncate conversion used by the output stage.
// Ports:   none (package).
package acc_pkg;

    // Widest value sat_conv can take; the accumulator is sign-extended into it.
    localparam int MAX_W = 128;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        for (int i = 0; i < 32; i++) begin
            if (v < n) begin
                v = v * 2;
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Operand count entering tree level k for an n-input tree.
    function automatic int level_count(input int n, input int k);
        int c;
        c = n;
        for (int i = 0; i < k; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    // Converts a signed value to out_w bits. With saturate set it clamps to the
    // signed out_w range and raises sat; otherwise the caller keeps the low
    // out_w bits (wrap) and sat stays 0.
    function automatic logic [MAX_W-1:0] sat_conv(
        input  logic signed [MAX_W-1:0] v,
        input  int                      out_w,
        input  bit                      saturate,
        output logic                    sat
    );
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = (MAX_W'(1) <<< (out_w - 1)) - MAX_W'(1);
        lo = ~hi;
        sat      = 1'b0;
        sat_conv = v;
        if (saturate) begin
            if (v > hi) begin
                sat_conv = hi;
                sat      = 1'b1;
            end else if (v < lo) begin
                sat_conv = lo;
                sat      = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// rtl/adder_tree_level.sv - one registered pairwise-add level of the adder tree
// Purpose: adds operand pairs (2j, 2j+1) into W+1 bit results; an odd leftover
//          operand is sign-extended and passed through. Beat flags are delayed
//          by the same single register stage.
// Ports:   clk, rst_n        clock, asynchronous active-low reset
//          i_valid/first/last beat flags in, o_valid/first/last flags out
//          i_data [N*W]       packed signed operands
//          o_data [NO*(W+1)]  packed signed results, NO = ceil(N/2)
module adder_tree_level #(
    parameter int N = 2,
    parameter int W = 32,
    localparam int NO = (N + 1) / 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic              i_first,
    input  logic              i_last,
    input  logic [N*W-1:0]    i_data,
    output logic              o_valid,
    output logic              o_first,
    output logic              o_last,
    output logic [NO*(W+1)-1:0] o_data
);

    logic r_valid;
    logic r_first;
    logic r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= i_valid;
            r_first <= i_first;
            r_last  <= i_last;
        end
    end

    assign o_valid = r_valid;
    assign o_first = r_first;
    assign o_last  = r_last;

    for (genvar j = 0; j < NO; j++) begin : g_op
        logic signed [W:0] w_op;
        logic signed [W:0] r_op;

        if (2 * j + 1 < N) begin : g_pair
            assign w_op = (W+1)'($signed(i_data[2*j*W +: W]))
                        + (W+1)'($signed(i_data[(2*j+1)*W +: W]));
        end else begin : g_pass
            assign w_op = (W+1)'($signed(i_data[2*j*W +: W]));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_op <= '0;
            end else begin
                r_op <= w_op;
            end
        end

        assign o_data[j*(W+1) +: W+1] = r_op;
    end

endmodule

// File: rtl/adder_tree_acc.sv
// rtl/adder_tree_acc.sv - pipelined N-input signed adder tree with frame accumulator
// Purpose: sums N_IN signed operands per beat through L = clog2(N_IN) registered
//          levels, accumulates tree sums over a first..last frame, and emits one
//          saturated or wrapped OUT_W result per frame, L+2 cycles after the last beat.
// Ports:   clk, rst_n                    clock, asynchronous active-low reset
//          in_valid, in_first, in_last   beat strobe and frame delimiters
//          in_data [N_IN*DATA_W]         packed signed operands
//          out_valid                     one-cycle pulse per completed frame
//          out_data [OUT_W], out_sat     frame result and clamp flag, held until next pulse
module adder_tree_acc
    import acc_pkg::*;
#(
    parameter int N_IN     = 9,
    parameter int DATA_W   = 32,
    parameter int OUT_W    = 32,
    parameter int GUARD_W  = 8,
    parameter int SATURATE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [N_IN*DATA_W-1:0] in_data,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_sat
);

    localparam int L     = clog2(N_IN);
    localparam int SUM_W = DATA_W + L;
    localparam int ACC_W = DATA_W + L + GUARD_W;

    logic signed [SUM_W-1:0] w_tree_sum;
    logic                    w_t_valid;
    logic                    w_t_first;
    logic                    w_t_last;

    if (L == 0) begin : g_notree
        assign w_tree_sum = in_data;
        assign w_t_valid  = in_valid;
        assign w_t_first  = in_first;
        assign w_t_last   = in_last;
    end else begin : g_tree
        for (genvar k = 0; k < L; k++) begin : g_lvl
            localparam int NK = level_count(N_IN, k);
            localparam int WK = DATA_W + k;
            localparam int NO = (NK + 1) / 2;

            logic [NK*WK-1:0]     w_in;
            logic                 w_iv;
            logic                 w_if;
            logic                 w_il;
            logic [NO*(WK+1)-1:0] w_out;
            logic                 w_ov;
            logic                 w_of;
            logic                 w_ol;

            if (k == 0) begin : g_head
                assign w_in = in_data;
                assign w_iv = in_valid;
                assign w_if = in_first;
                assign w_il = in_last;
            end else begin : g_chain
                assign w_in = g_lvl[k-1].w_out;
                assign w_iv = g_lvl[k-1].w_ov;
                assign w_if = g_lvl[k-1].w_of;
                assign w_il = g_lvl[k-1].w_ol;
            end

            adder_tree_level #(
                .N (NK),
                .W (WK)
            ) u_level (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_valid (w_iv),
                .i_first (w_if),
                .i_last  (w_il),
                .i_data  (w_in),
                .o_valid (w_ov),
                .o_first (w_of),
                .o_last  (w_ol),
                .o_data  (w_out)
            );
        end

        // The last level always reduces to a single SUM_W operand.
        assign w_tree_sum = g_lvl[L-1].w_out;
        assign w_t_valid  = g_lvl[L-1].w_ov;
        assign w_t_first  = g_lvl[L-1].w_of;
        assign w_t_last   = g_lvl[L-1].w_ol;
    end

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_open;
    logic                    r_acc_done;
    logic signed [ACC_W-1:0] w_acc_ext;
    logic signed [ACC_W-1:0] w_acc_next;

    assign w_acc_ext = ACC_W'(w_tree_sum);

    // A first beat, or any beat arriving with no frame open, starts a fresh
    // frame; this also drops a partial frame that never saw its last beat.
    always_comb begin
        w_acc_next = r_acc;
        if (w_t_first || !r_open) begin
            w_acc_next = w_acc_ext;
        end else begin
            w_acc_next = r_acc + w_acc_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_open     <= 1'b0;
            r_acc_done <= 1'b0;
        end else begin
            r_acc_done <= w_t_valid && w_t_last;
            if (w_t_valid) begin
                r_acc  <= w_acc_next;
                r_open <= !w_t_last;
            end
        end
    end

    logic [OUT_W-1:0] w_out_conv;
    logic             w_out_sat;

    always_comb begin
        w_out_sat  = 1'b0;
        w_out_conv = OUT_W'(sat_conv(MAX_W'(r_acc), OUT_W, SATURATE != 0, w_out_sat));
    end

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_out_valid <= r_acc_done;
            if (r_acc_done) begin
                r_out_data <= w_out_conv;
                r_out_sat  <= w_out_sat;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_adder_tree_acc.sv
// tb/tb_adder_tree_acc.sv - self-checking bench for adder_tree_acc (saturating and wrapping)
module tb_adder_tree_acc;

    localparam int N_IN   = 9;
    localparam int DATA_W = 32;
    localparam int OUT_W  = 32;
    localparam int LAT    = 6;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_first = 1'b0;
    logic                   in_last = 1'b0;
    logic [N_IN*DATA_W-1:0] in_data = '0;

    logic             out_valid_s;
    logic [OUT_W-1:0] out_data_s;
    logic             out_sat_s;
    logic             out_valid_w;
    logic [OUT_W-1:0] out_data_w;
    logic             out_sat_w;

    adder_tree_acc #(
        .N_IN(N_IN), .DATA_W(DATA_W), .OUT_W(OUT_W), .GUARD_W(8), .SATURATE(1)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .in_data(in_data),
        .out_valid(out_valid_s), .out_data(out_data_s), .out_sat(out_sat_s)
    );

    adder_tree_acc #(
        .N_IN(N_IN), .DATA_W(DATA_W), .OUT_W(OUT_W), .GUARD_W(8), .SATURATE(0)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .in_data(in_data),
        .out_valid(out_valid_w), .out_data(out_data_w), .out_sat(out_sat_w)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d_s;
        logic        s_s;
        logic [31:0] d_w;
        int          due;
    } exp_t;

    exp_t        q[$];
    longint      m_acc = 0;
    bit          m_open = 0;
    logic [31:0] last_d_s = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_result(input longint v, input int due);
        exp_t        e;
        logic [63:0] a;
        a     = v;
        e.d_w = a[31:0];
        e.due = due;
        if (v > 64'sd2147483647) begin
            e.d_s = 32'h7FFF_FFFF;
            e.s_s = 1'b1;
        end else if (v < -64'sd2147483648) begin
            e.d_s = 32'h8000_0000;
            e.s_s = 1'b1;
        end else begin
            e.d_s = a[31:0];
            e.s_s = 1'b0;
        end
        last_d_s = e.d_s;
        q.push_back(e);
    endtask

    task automatic beat(input bit f, input bit l, input int v);
        @(negedge clk);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        for (int i = 0; i < N_IN; i++) in_data[i*DATA_W +: DATA_W] = v;
        if (f || !m_open) m_acc = longint'(v) * N_IN;
        else              m_acc = m_acc + longint'(v) * N_IN;
        m_open = !l;
        if (l) push_result(m_acc, cyc + LAT);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_first = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Scoreboard: pops the head entry on the cycle it is due and flags any
    // pulse that is early, late or unexpected.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0 && q[0].due < cyc) begin
                check("late_result_cycle", 64'(cyc), 64'(q[0].due));
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                check("valid_sat", 64'(out_valid_s), 64'd1);
                check("valid_wrap", 64'(out_valid_w), 64'd1);
                check("data_sat", 64'(out_data_s), 64'(e.d_s));
                check("flag_sat", 64'(out_sat_s), 64'(e.s_s));
                check("data_wrap", 64'(out_data_w), 64'(e.d_w));
                check("flag_wrap", 64'(out_sat_w), 64'd0);
            end else if (out_valid_s || out_valid_w) begin
                check("unexpected_valid_sat", 64'(out_valid_s), 64'd0);
                check("unexpected_valid_wrap", 64'(out_valid_w), 64'd0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid_sat", 64'(out_valid_s), 64'd0);
        check("rst_data_sat", 64'(out_data_s), 64'd0);
        check("rst_flag_sat", 64'(out_sat_s), 64'd0);
        check("rst_valid_wrap", 64'(out_valid_w), 64'd0);
        check("rst_data_wrap", 64'(out_data_w), 64'd0);
        check("rst_flag_wrap", 64'(out_sat_w), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // single-beat frames: ones, then -5s
        beat(1, 1, 1);
        idle(10);
        beat(1, 1, -5);
        idle(10);

        // three beats of max positive: clamps vs wraps
        beat(1, 0, 32'h7FFF_FFFF);
        beat(0, 0, 32'h7FFF_FFFF);
        beat(0, 1, 32'h7FFF_FFFF);
        idle(10);

        // four beats with 0..3 bubbles in between, then hold check
        beat(1, 0, 1);
        beat(0, 0, 1);
        idle(1);
        beat(0, 0, 1);
        idle(2);
        beat(0, 1, 1);
        idle(3);
        idle(12);
        check("hold_data_sat", 64'(out_data_s), 64'(last_d_s));
        check("hold_flag_sat", 64'(out_sat_s), 64'd0);

        // back-to-back single-beat frames
        for (int k = 1; k <= 8; k++) beat(1, 1, k);
        idle(12);

        // reset in the middle of a frame discards the partial
        beat(1, 0, 1);
        beat(0, 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        m_open   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        beat(1, 1, 2);
        idle(10);

        // a new first beat restarts the frame
        beat(1, 0, 1);
        beat(0, 0, 1);
        beat(1, 1, 3);
        idle(10);

        begin
            int budget;
            budget = 0;
            while (q.size() > 0 && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (q.size() > 0) check("drain_pending", 64'(q.size()), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
